l1_cache: RTL and testbench
===========================

Name: l1_cache

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache between the CPU load/store port and the L2 cache.
- Serves read hits locally.
- On a read miss, refills a whole line from L2 using sequential single-word L2 reads.
- Forwards every write to L2; a hit also updates the local copy.

Parameters:
- DATA_WIDTH, 32, word width in bits; byte-addressed, word = DATA_WIDTH/8 bytes.
- ADDR_WIDTH, 32, address width.
- CACHE_SIZE, 256, capacity in bytes.
- BLOCK_SIZE, 16, line size in bytes.
- Derived: LINES = CACHE_SIZE/BLOCK_SIZE = 16.
- Derived: WPL (words per line) = BLOCK_SIZE/(DATA_WIDTH/8) = 4.
- Derived: OFF_W = clog2(BLOCK_SIZE), IDX_W = clog2(LINES), TAG_W = ADDR_WIDTH-IDX_W-OFF_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cpu_addr  in  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_read  in  1  load request (level)
- cpu_write  in  1  store request (level)
- cpu_rdata  out  DATA_WIDTH  load data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- cpu_hit  out  1  qualifies cpu_ready: 1 = L1 hit
- l2_addr  out  ADDR_WIDTH  L2 request address (word aligned)
- l2_wdata  out  DATA_WIDTH  L2 store data
- l2_read  out  1  L2 read request
- l2_write  out  1  L2 write request
- l2_rdata  in  DATA_WIDTH  L2 read data, valid with l2_ready
- l2_ready  in  1  L2 completion pulse
- l2_hit  in  1  L2 hit flag; used only for statistics
- stat_hits  out  16  L1 hit counter, saturating
- stat_misses  out  16  L1 miss counter, saturating

Behaviour:
- Reset (async, takes effect immediately, even mid-transaction):
  - All valid bits cleared; FSM forced to IDLE; any in-flight L2 transaction abandoned.
  - cpu_ready, cpu_hit, l2_read, l2_write = 0; cpu_rdata, l2_addr, l2_wdata = 0; counters = 0.
  - Tag/data arrays are not reset.
- All outputs are registered.
- FSM states: IDLE, LOOKUP, FILL, WRITE_THRU.
- IDLE:
  - If cpu_write or cpu_read: latch addr/wdata/op, go to LOOKUP.
  - cpu_write has priority when both are asserted; the op is a store.
  - CPU must hold its request until cpu_ready; the request is re-sampled only in IDLE.
- LOOKUP: hit = valid[idx] && tag[idx]==tag.
  - Read hit: cpu_rdata = word, cpu_ready=1, cpu_hit=1 (read-hit latency: ready 2 cycles after the IDLE sampling edge). stat_hits++. Go to IDLE.
  - Read miss: stat_misses++; l2_addr = {tag, idx, 0}; l2_read=1; beat=0; go to FILL.
  - Write, hit or miss: if hit, update data[idx][word] and stat_hits++, else stat_misses++. Then l2_addr = word-aligned addr, l2_wdata = data, l2_write=1, go to WRITE_THRU. A write miss does not allocate.
- FILL:
  - Hold l2_read=1 and l2_addr until l2_ready.
  - On l2_ready: data[idx][beat] = l2_rdata; if the beat is the requested word, also capture it for cpu_rdata.
  - If beat < WPL-1: beat++, l2_addr += DATA_WIDTH/8, and l2_read stays 1.
  - Last beat: l2_read=0, tag/valid written, cpu_ready=1, cpu_hit=0, go to IDLE.
  - Valid is set only after the last beat. A reset mid-fill therefore leaves the line invalid.
- WRITE_THRU: hold l2_write/l2_addr/l2_wdata until l2_ready. Then l2_write=0, cpu_ready=1, cpu_hit=(LOOKUP hit), go to IDLE.
- l2_read and l2_write are never asserted together. Both are deasserted on the edge that samples the final l2_ready.
- Counters saturate at 0xFFFF.
- l2_hit has no functional effect; it is latched only for debug.

Decomposition:
- Package cache_pkg holds:
  - FSM state encoding.
  - Width-derivation constants/functions (OFF_W, IDX_W, TAG_W, WPL).
  - Address-split helper functions, shared with L2.
- One natural sub-module, l1_line_store:
  - tag/valid/data arrays; synchronous write; combinational read by index.
  - Valid clear on reset.

Test Plan:
- Reset, then read 0x0000_0040 (L2 model returns addr^0xA5A50000):
  - 4 L2 reads at 0x40, 0x44, 0x48, 0x4C.
  - cpu_rdata=0xA5A50040, cpu_hit=0, stat_misses=1.
- Then read 0x0000_0048:
  - No L2 activity; ready 2 cycles after request; cpu_rdata=0xA5A50048, cpu_hit=1, stat_hits=1.
- Write 0xDEADBEEF to 0x44 (line resident):
  - L2 write at 0x44 with 0xDEADBEEF; cpu_hit=1.
  - A following read of 0x44 hits and returns 0xDEADBEEF.
- Write 0x12345678 to 0x1000 (miss):
  - L2 write issued; cpu_hit=0.
  - A following read of 0x1000 misses and issues a 4-beat fill.
- Conflict: read 0x40, then read 0x140 (same index, different tag):
  - Refill evicts; a re-read of 0x40 misses again.
- Reset asserted during beat 2 of a fill of 0x80:
  - Outputs go to reset values immediately.
  - After reset, a read of 0x80 misses.
  - Also: cpu_read and cpu_write high together → only an L2 write is issued.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared cache definitions: FSM encoding, geometry derivation
//                and address-split helpers (used by L1 and L2).
//  Revision    : 1.0  initial release
// ============================================================================
package cache_pkg;

    // Widest address the split helpers accept; callers size-cast in and out.
    localparam int ADDR_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOOKUP     = 2'd1,
        ST_FILL       = 2'd2,
        ST_WRITE_THRU = 2'd3
    } state_t;

    function automatic int calc_lines(input int cache_size, input int block_size);
        return cache_size / block_size;
    endfunction

    function automatic int calc_wpl(input int block_size, input int data_width);
        return block_size / (data_width / 8);
    endfunction

    function automatic int calc_off_w(input int block_size);
        return $clog2(block_size);
    endfunction

    function automatic int calc_idx_w(input int cache_size, input int block_size);
        return $clog2(cache_size / block_size);
    endfunction

    function automatic int calc_tag_w(input int addr_width, input int cache_size,
                                      input int block_size);
        return addr_width - calc_idx_w(cache_size, block_size) - calc_off_w(block_size);
    endfunction

    // Extract 'width' bits of 'addr' starting at bit 'lsb'.
    function automatic logic [ADDR_MAX-1:0] addr_field(input logic [ADDR_MAX-1:0] addr,
                                                       input int lsb, input int width);
        logic [ADDR_MAX-1:0] mask;
        mask = (width >= ADDR_MAX) ? '1 : ((ADDR_MAX'(1) << width) - ADDR_MAX'(1));
        return (addr >> lsb) & mask;
    endfunction

    function automatic logic [ADDR_MAX-1:0] addr_tag(input logic [ADDR_MAX-1:0] addr,
                                                     input int off_w, input int idx_w);
        return addr_field(addr, off_w + idx_w, ADDR_MAX);
    endfunction

    function automatic logic [ADDR_MAX-1:0] addr_index(input logic [ADDR_MAX-1:0] addr,
                                                       input int off_w, input int idx_w);
        return addr_field(addr, off_w, idx_w);
    endfunction

    // Word number inside the line (byte-within-word bits dropped).
    function automatic logic [ADDR_MAX-1:0] addr_word(input logic [ADDR_MAX-1:0] addr,
                                                      input int off_w, input int byte_w);
        return addr_field(addr, byte_w, off_w - byte_w);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/l1_cache_if.sv
`default_nettype none
// ============================================================================
//  Module      : l1_cache_if
//  Description : CPU load/store port and L2 request port of the L1 cache.
//                slave  = the cache's view; master = the CPU + L2 side.
//  Revision    : 1.0  initial release
// ============================================================================
interface l1_cache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_read;
    logic                  cpu_write;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ready;
    logic                  cpu_hit;
    logic [ADDR_WIDTH-1:0] l2_addr;
    logic [DATA_WIDTH-1:0] l2_wdata;
    logic                  l2_read;
    logic                  l2_write;
    logic [DATA_WIDTH-1:0] l2_rdata;
    logic                  l2_ready;
    logic                  l2_hit;
    logic                  dbg_l2_hit;   // last l2_hit seen with l2_ready

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_read, cpu_write,
        output cpu_rdata, cpu_ready, cpu_hit,
        output l2_addr, l2_wdata, l2_read, l2_write,
        input  l2_rdata, l2_ready, l2_hit,
        output dbg_l2_hit
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_read, cpu_write,
        input  cpu_rdata, cpu_ready, cpu_hit,
        input  l2_addr, l2_wdata, l2_read, l2_write,
        output l2_rdata, l2_ready, l2_hit,
        input  dbg_l2_hit
    );
endinterface
`default_nettype wire

// File: rtl/l1_line_store.sv
`default_nettype none
// ============================================================================
//  Module      : l1_line_store
//  Description : Tag / valid / data arrays of the direct-mapped L1.
//                Synchronous writes, combinational read by index.
//  Revision    : 1.0  initial release
// ============================================================================
module l1_line_store #(
    parameter int LINES      = 16,
    parameter int WPL        = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_W      = 24,
    parameter int IDX_W      = 4,
    parameter int WSEL_W     = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic [IDX_W-1:0]      rd_idx_i,
    input  wire logic [WSEL_W-1:0]     rd_word_i,
    output logic                       rd_valid_o,
    output logic [TAG_W-1:0]           rd_tag_o,
    output logic [DATA_WIDTH-1:0]      rd_data_o,
    input  wire logic [IDX_W-1:0]      wr_idx_i,
    input  wire logic                  data_we_i,
    input  wire logic [WSEL_W-1:0]     wr_word_i,
    input  wire logic [DATA_WIDTH-1:0] wr_data_i,
    input  wire logic                  tag_we_i,   // writes tag and sets valid
    input  wire logic [TAG_W-1:0]      wr_tag_i,
    input  wire logic                  inval_i     // clears valid of wr_idx_i
);
    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [LINES][WPL];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_mem[rd_idx_i];
    assign rd_data_o  = data_mem[rd_idx_i][rd_word_i];

    // Valid bits are the only reset state; a line becomes valid only when its tag is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (tag_we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end else if (inval_i) begin
            valid_q[wr_idx_i] <= 1'b0;
        end
    end

    // Tag and data storage, not reset.
    always_ff @(posedge clk) begin
        if (data_we_i) data_mem[wr_idx_i][wr_word_i] <= wr_data_i;
        if (tag_we_i)  tag_mem[wr_idx_i]             <= wr_tag_i;
    end
endmodule
`default_nettype wire

// File: rtl/l1_cache.sv
`default_nettype none
// ============================================================================
//  Module      : l1_cache
//  Description : Direct-mapped, write-through, no-write-allocate L1 D-cache.
//                Read misses refill the whole line with single-word L2 reads.
//  Revision    : 1.0  initial release
// ============================================================================
module l1_cache
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CACHE_SIZE = 256,
    parameter int BLOCK_SIZE = 16
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    l1_cache_if.slave   bus,
    output logic [15:0] stat_hits,
    output logic [15:0] stat_misses
);
    localparam int LINES  = calc_lines(CACHE_SIZE, BLOCK_SIZE);
    localparam int WPL    = calc_wpl(BLOCK_SIZE, DATA_WIDTH);
    localparam int OFF_W  = calc_off_w(BLOCK_SIZE);
    localparam int IDX_W  = calc_idx_w(CACHE_SIZE, BLOCK_SIZE);
    localparam int TAG_W  = calc_tag_w(ADDR_WIDTH, CACHE_SIZE, BLOCK_SIZE);
    localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
    localparam int WSEL_W = $clog2(WPL);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  is_wr_q, is_wr_d;
    logic [WSEL_W-1:0]     beat_q, beat_d;
    logic                  hit_q, hit_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic                  cpu_ready_q, cpu_ready_d;
    logic                  cpu_hit_q, cpu_hit_d;
    logic [ADDR_WIDTH-1:0] l2_addr_q, l2_addr_d;
    logic [DATA_WIDTH-1:0] l2_wdata_q, l2_wdata_d;
    logic                  l2_read_q, l2_read_d;
    logic                  l2_write_q, l2_write_d;
    logic [15:0]           hits_q, hits_d, misses_q, misses_d;
    logic                  dbg_q, dbg_d;

    logic [TAG_W-1:0]      w_tag, rd_tag;
    logic [IDX_W-1:0]      w_idx;
    logic [WSEL_W-1:0]     w_word, data_word;
    logic                  rd_valid, w_hit, data_we, tag_we, inval;
    logic [DATA_WIDTH-1:0] rd_data, data_in;

    assign w_tag  = TAG_W'(addr_tag(ADDR_MAX'(addr_q), OFF_W, IDX_W));
    assign w_idx  = IDX_W'(addr_index(ADDR_MAX'(addr_q), OFF_W, IDX_W));
    assign w_word = WSEL_W'(addr_word(ADDR_MAX'(addr_q), OFF_W, BYTE_W));
    assign w_hit  = rd_valid && (rd_tag == w_tag);

    l1_line_store #(
        .LINES(LINES), .WPL(WPL), .DATA_WIDTH(DATA_WIDTH),
        .TAG_W(TAG_W), .IDX_W(IDX_W), .WSEL_W(WSEL_W)
    ) u_store (
        .clk(clk), .rst_n(rst_n),
        .rd_idx_i(w_idx), .rd_word_i(w_word),
        .rd_valid_o(rd_valid), .rd_tag_o(rd_tag), .rd_data_o(rd_data),
        .wr_idx_i(w_idx), .data_we_i(data_we), .wr_word_i(data_word), .wr_data_i(data_in),
        .tag_we_i(tag_we), .wr_tag_i(w_tag), .inval_i(inval)
    );

    // State and every output register; reset abandons any L2 transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            is_wr_q     <= 1'b0;
            beat_q      <= '0;
            hit_q       <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            cpu_hit_q   <= 1'b0;
            l2_addr_q   <= '0;
            l2_wdata_q  <= '0;
            l2_read_q   <= 1'b0;
            l2_write_q  <= 1'b0;
            hits_q      <= '0;
            misses_q    <= '0;
            dbg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            is_wr_q     <= is_wr_d;
            beat_q      <= beat_d;
            hit_q       <= hit_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_hit_q   <= cpu_hit_d;
            l2_addr_q   <= l2_addr_d;
            l2_wdata_q  <= l2_wdata_d;
            l2_read_q   <= l2_read_d;
            l2_write_q  <= l2_write_d;
            hits_q      <= hits_d;
            misses_q    <= misses_d;
            dbg_q       <= dbg_d;
        end
    end

    // Next-state, output and array-write decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        is_wr_d     = is_wr_q;
        beat_d      = beat_q;
        hit_d       = hit_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        cpu_hit_d   = 1'b0;
        l2_addr_d   = l2_addr_q;
        l2_wdata_d  = l2_wdata_q;
        l2_read_d   = l2_read_q;
        l2_write_d  = l2_write_q;
        hits_d      = hits_q;
        misses_d    = misses_q;
        dbg_d       = dbg_q;
        data_we     = 1'b0;
        data_word   = w_word;
        data_in     = wdata_q;
        tag_we      = 1'b0;
        inval       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_write || bus.cpu_read) begin
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    is_wr_d = bus.cpu_write;   // store wins when both are raised
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                hit_d = w_hit;
                if (is_wr_q) begin
                    if (w_hit) begin
                        data_we = 1'b1;
                        hits_d  = sat_inc16(hits_q);
                    end else begin
                        misses_d = sat_inc16(misses_q);
                    end
                    l2_addr_d  = {addr_q[ADDR_WIDTH-1:BYTE_W], BYTE_W'(0)};
                    l2_wdata_d = wdata_q;
                    l2_write_d = 1'b1;
                    state_d    = ST_WRITE_THRU;
                end else if (w_hit) begin
                    cpu_rdata_d = rd_data;
                    cpu_ready_d = 1'b1;
                    cpu_hit_d   = 1'b1;
                    hits_d      = sat_inc16(hits_q);
                    state_d     = ST_IDLE;
                end else begin
                    // The victim line is dropped now so a partial refill never looks valid.
                    misses_d  = sat_inc16(misses_q);
                    inval     = 1'b1;
                    l2_addr_d = {w_tag, w_idx, OFF_W'(0)};
                    l2_read_d = 1'b1;
                    beat_d    = '0;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                if (bus.l2_ready) begin
                    dbg_d     = bus.l2_hit;
                    data_we   = 1'b1;
                    data_word = beat_q;
                    data_in   = bus.l2_rdata;
                    if (beat_q == w_word) cpu_rdata_d = bus.l2_rdata;
                    if (beat_q == WSEL_W'(WPL - 1)) begin
                        l2_read_d   = 1'b0;
                        tag_we      = 1'b1;
                        cpu_ready_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        beat_d    = beat_q + WSEL_W'(1);
                        l2_addr_d = l2_addr_q + ADDR_WIDTH'(DATA_WIDTH / 8);
                    end
                end
            end
            ST_WRITE_THRU: begin
                if (bus.l2_ready) begin
                    dbg_d       = bus.l2_hit;
                    l2_write_d  = 1'b0;
                    cpu_ready_d = 1'b1;
                    cpu_hit_d   = hit_q;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_ready  = cpu_ready_q;
    assign bus.cpu_hit    = cpu_hit_q;
    assign bus.l2_addr    = l2_addr_q;
    assign bus.l2_wdata   = l2_wdata_q;
    assign bus.l2_read    = l2_read_q;
    assign bus.l2_write   = l2_write_q;
    assign bus.dbg_l2_hit = dbg_q;
    assign stat_hits      = hits_q;
    assign stat_misses    = misses_q;
endmodule
`default_nettype wire

// File: tb/tb_l1_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l1_cache
//  Description : Directed self-checking bench for l1_cache with an L2 model
//                that answers reads with addr ^ 0xA5A50000.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_l1_cache;
    logic        clk;
    logic        rst_n;
    logic [15:0] stat_hits, stat_misses;
    int          checks, failures;

    // L2 transaction log filled by the L2 model.
    logic [31:0] log_addr  [64];
    logic        log_wr    [64];
    logic [31:0] log_wdata [64];
    int          l2_n;
    int          both_cnt;

    l1_cache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    l1_cache dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .stat_hits(stat_hits), .stat_misses(stat_misses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // L2 model: one-cycle ready pulse for each request, one idle cycle between beats.
    initial begin
        bus.l2_ready = 1'b0;
        bus.l2_rdata = '0;
        bus.l2_hit   = 1'b0;
        l2_n         = 0;
        both_cnt     = 0;
        forever begin
            @(negedge clk);
            if (bus.l2_read && bus.l2_write) both_cnt++;
            if (!rst_n || bus.l2_ready) begin
                bus.l2_ready = 1'b0;
            end else if (bus.l2_read || bus.l2_write) begin
                if (l2_n < 64) begin
                    log_addr[l2_n]  = bus.l2_addr;
                    log_wr[l2_n]    = bus.l2_write;
                    log_wdata[l2_n] = bus.l2_wdata;
                end
                l2_n++;
                bus.l2_rdata = bus.l2_addr ^ 32'hA5A5_0000;
                bus.l2_hit   = 1'b1;
                bus.l2_ready = 1'b1;
            end
        end
    end

    task automatic cpu_req(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] rdata,
                           output logic hit, output int cyc);
        @(negedge clk);
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        bus.cpu_write = wr;
        bus.cpu_read  = rd;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus.cpu_ready && cyc < 200);
        checks++;
        if (!bus.cpu_ready) begin
            failures++;
            $display("FAIL req_timeout addr=%h: got no cpu_ready, required ready within 200 cycles", addr);
        end
        rdata = bus.cpu_rdata;
        hit   = bus.cpu_hit;
        bus.cpu_write = 1'b0;
        bus.cpu_read  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.cpu_ready, bus.cpu_hit, bus.l2_read, bus.l2_write} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 0000",
                     {bus.cpu_ready, bus.cpu_hit, bus.l2_read, bus.l2_write});
        end
        checks++;
        if ({bus.cpu_rdata, bus.l2_addr, bus.l2_wdata, stat_hits, stat_misses} !== '0) begin
            failures++;
            $display("FAIL reset_data: got rdata=%h l2_addr=%h l2_wdata=%h hits=%h misses=%h required all 0",
                     bus.cpu_rdata, bus.l2_addr, bus.l2_wdata, stat_hits, stat_misses);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_miss();
        logic [31:0] rd; logic hit; int cyc; int base;
        base = l2_n;
        cpu_req(1'b0, 1'b1, 32'h40, '0, rd, hit, cyc);
        checks++;
        if (l2_n - base !== 4) begin
            failures++; $display("FAIL miss_beats: got %0d required 4", l2_n - base);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_addr[base+i] !== 32'h40 + 32'(4*i) || log_wr[base+i] !== 1'b0) begin
                failures++;
                $display("FAIL miss_beat%0d: got addr=%h wr=%b required addr=%h wr=0",
                         i, log_addr[base+i], log_wr[base+i], 32'h40 + 32'(4*i));
            end
        end
        checks++;
        if (rd !== 32'hA5A5_0040 || hit !== 1'b0 || stat_misses !== 16'd1) begin
            failures++;
            $display("FAIL miss_result: got rdata=%h hit=%b misses=%0d required A5A50040/0/1",
                     rd, hit, stat_misses);
        end
        checks++;
        if (bus.dbg_l2_hit !== 1'b1 || bus.l2_read !== 1'b0) begin
            failures++;
            $display("FAIL miss_after: got dbg_l2_hit=%b l2_read=%b required 1/0",
                     bus.dbg_l2_hit, bus.l2_read);
        end
    endtask

    task automatic test_read_hit();
        logic [31:0] rd; logic hit; int cyc; int base;
        base = l2_n;
        cpu_req(1'b0, 1'b1, 32'h48, '0, rd, hit, cyc);
        checks++;
        if (l2_n !== base || cyc !== 2) begin
            failures++;
            $display("FAIL hit_latency: got l2_txns=%0d cycles=%0d required 0/2", l2_n - base, cyc);
        end
        checks++;
        if (rd !== 32'hA5A5_0048 || hit !== 1'b1 || stat_hits !== 16'd1) begin
            failures++;
            $display("FAIL hit_result: got rdata=%h hit=%b hits=%0d required A5A50048/1/1",
                     rd, hit, stat_hits);
        end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd; logic hit; int cyc; int base;
        base = l2_n;
        cpu_req(1'b1, 1'b0, 32'h44, 32'hDEAD_BEEF, rd, hit, cyc);
        checks++;
        if (l2_n - base !== 1 || log_wr[base] !== 1'b1 || log_addr[base] !== 32'h44 ||
            log_wdata[base] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL wr_hit_l2: got n=%0d wr=%b addr=%h data=%h required 1/1/00000044/DEADBEEF",
                     l2_n - base, log_wr[base], log_addr[base], log_wdata[base]);
        end
        checks++;
        if (hit !== 1'b1 || stat_hits !== 16'd2) begin
            failures++; $display("FAIL wr_hit_flag: got hit=%b hits=%0d required 1/2", hit, stat_hits);
        end
        base = l2_n;
        cpu_req(1'b0, 1'b1, 32'h44, '0, rd, hit, cyc);
        checks++;
        if (rd !== 32'hDEAD_BEEF || hit !== 1'b1 || l2_n !== base) begin
            failures++;
            $display("FAIL wr_hit_readback: got rdata=%h hit=%b l2_txns=%0d required DEADBEEF/1/0",
                     rd, hit, l2_n - base);
        end
    endtask

    task automatic test_write_miss();
        logic [31:0] rd; logic hit; int cyc; int base;
        base = l2_n;
        cpu_req(1'b1, 1'b0, 32'h1000, 32'h1234_5678, rd, hit, cyc);
        checks++;
        if (l2_n - base !== 1 || log_wr[base] !== 1'b1 || log_addr[base] !== 32'h1000 ||
            log_wdata[base] !== 32'h1234_5678 || hit !== 1'b0 || stat_misses !== 16'd2) begin
            failures++;
            $display("FAIL wr_miss: got n=%0d wr=%b addr=%h data=%h hit=%b misses=%0d required 1/1/00001000/12345678/0/2",
                     l2_n - base, log_wr[base], log_addr[base], log_wdata[base], hit, stat_misses);
        end
        base = l2_n;
        cpu_req(1'b0, 1'b1, 32'h1000, '0, rd, hit, cyc);
        checks++;
        if (l2_n - base !== 4 || log_addr[base] !== 32'h1000 || log_addr[base+3] !== 32'h100C ||
            rd !== 32'hA5A5_1000 || hit !== 1'b0 || stat_misses !== 16'd3) begin
            failures++;
            $display("FAIL wr_miss_noalloc: got n=%0d first=%h last=%h rdata=%h hit=%b misses=%0d required 4/00001000/0000100C/A5A51000/0/3",
                     l2_n - base, log_addr[base], log_addr[base+3], rd, hit, stat_misses);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] rd; logic hit; int cyc; int base;
        cpu_req(1'b0, 1'b1, 32'h40, '0, rd, hit, cyc);
        checks++;
        if (rd !== 32'hA5A5_0040 || hit !== 1'b1 || stat_hits !== 16'd4) begin
            failures++;
            $display("FAIL conflict_first: got rdata=%h hit=%b hits=%0d required A5A50040/1/4", rd, hit, stat_hits);
        end
        base = l2_n;
        cpu_req(1'b0, 1'b1, 32'h140, '0, rd, hit, cyc);
        checks++;
        if (rd !== 32'hA5A5_0140 || hit !== 1'b0 || l2_n - base !== 4 || log_addr[base] !== 32'h140) begin
            failures++;
            $display("FAIL conflict_evict: got rdata=%h hit=%b n=%0d first=%h required A5A50140/0/4/00000140",
                     rd, hit, l2_n - base, log_addr[base]);
        end
        base = l2_n;
        cpu_req(1'b0, 1'b1, 32'h40, '0, rd, hit, cyc);
        checks++;
        if (rd !== 32'hA5A5_0040 || hit !== 1'b0 || l2_n - base !== 4 || stat_misses !== 16'd5) begin
            failures++;
            $display("FAIL conflict_reread: got rdata=%h hit=%b n=%0d misses=%0d required A5A50040/0/4/5",
                     rd, hit, l2_n - base, stat_misses);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] rd; logic hit; int cyc; int base;
        @(negedge clk);
        bus.cpu_addr = 32'h80; bus.cpu_read = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!(bus.l2_read && bus.l2_addr == 32'h88) && cyc < 100);
        checks++;
        if (!(bus.l2_read && bus.l2_addr == 32'h88)) begin
            failures++; $display("FAIL fill_beat2_wait: got l2_addr=%h required beat 2 at 00000088", bus.l2_addr);
        end
        #1;
        rst_n = 1'b0;
        bus.cpu_read = 1'b0;
        #1;
        checks++;
        if ({bus.l2_read, bus.l2_write, bus.cpu_ready, bus.cpu_hit} !== 4'b0 ||
            {bus.l2_addr, bus.cpu_rdata, stat_hits, stat_misses} !== '0) begin
            failures++;
            $display("FAIL async_reset: got rd=%b wr=%b rdy=%b l2_addr=%h rdata=%h hits=%0d misses=%0d required all 0",
                     bus.l2_read, bus.l2_write, bus.cpu_ready, bus.l2_addr, bus.cpu_rdata, stat_hits, stat_misses);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = l2_n;
        cpu_req(1'b0, 1'b1, 32'h80, '0, rd, hit, cyc);
        checks++;
        if (hit !== 1'b0 || l2_n - base !== 4 || log_addr[base] !== 32'h80 ||
            rd !== 32'hA5A5_0080 || stat_misses !== 16'd1) begin
            failures++;
            $display("FAIL post_reset_miss: got hit=%b n=%0d first=%h rdata=%h misses=%0d required 0/4/00000080/A5A50080/1",
                     hit, l2_n - base, log_addr[base], rd, stat_misses);
        end
    endtask

    task automatic test_read_write_both();
        logic [31:0] rd; logic hit; int cyc; int base;
        base = l2_n;
        cpu_req(1'b1, 1'b1, 32'h80, 32'hCAFE_F00D, rd, hit, cyc);
        checks++;
        if (l2_n - base !== 1 || log_wr[base] !== 1'b1 || log_addr[base] !== 32'h80 ||
            log_wdata[base] !== 32'hCAFE_F00D || hit !== 1'b1) begin
            failures++;
            $display("FAIL both_req: got n=%0d wr=%b addr=%h data=%h hit=%b required 1/1/00000080/CAFEF00D/1",
                     l2_n - base, log_wr[base], log_addr[base], log_wdata[base], hit);
        end
        cpu_req(1'b0, 1'b1, 32'h80, '0, rd, hit, cyc);
        checks++;
        if (rd !== 32'hCAFE_F00D || hit !== 1'b1) begin
            failures++; $display("FAIL both_readback: got rdata=%h hit=%b required CAFEF00D/1", rd, hit);
        end
        checks++;
        if (both_cnt !== 0) begin
            failures++; $display("FAIL l2_exclusive: got %0d cycles with read+write required 0", both_cnt);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_reset_mid_fill();
        test_read_write_both();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
